// File: rtl/mac_row_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_row_pipe
// Purpose  : Systolic MAC row. One activation stream is skewed across COLS
//            columns; column k computes co[k] = fit(ci[k] + x_k * wa[k]).
//            Per-column valid tracking, global stall, signed/unsigned mode,
//            optional output saturation, and a double-buffered serial weight
//            loader so a new weight set can stream in while the row computes.
// Ports    : clk, rst (async, active-high)
//            stall            - freeze skew/valid/result registers
//            sgn              - 1: signed two's complement, 0: unsigned
//            x_valid, xi      - activation entering column 0
//            ci               - pre-skewed partial sums, column k at [k*CW +: CW]
//            w_valid, w_data  - serial weight beats (first beat -> column 0)
//            w_ready          - loader accepts a beat
//            w_commit         - copy full shadow bank into active bank
//            w_full           - shadow bank complete, awaiting commit
//            co, co_valid     - results, column k at [k*OW +: OW]
// Revision : 1.0 - initial release
// ============================================================================
module mac_row_pipe #(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int CW   = 16,
    parameter int OW   = 17,
    parameter int COLS = 6,
    parameter int SAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 sgn,
    input  logic                 x_valid,
    input  logic [DW-1:0]        xi,
    input  logic [COLS*CW-1:0]   ci,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [WW-1:0]        w_data,
    input  logic                 w_commit,
    output logic                 w_full,
    output logic [COLS*OW-1:0]   co,
    output logic [COLS-1:0]      co_valid
);

    // Full internal width: wide enough for the product and the addend plus carry.
    localparam int FW = ((CW > DW + WW) ? CW : DW + WW) + 1;
    localparam int IW = $clog2(COLS);
    localparam logic [IW-1:0] C_LAST = IW'(COLS - 1);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    // ------------------------------------------------------------------
    // Weight loader
    // ------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [WW-1:0] r_ws [COLS];
    logic [WW-1:0] r_wa [COLS];
    logic          w_load_beat;
    logic          w_commit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_valid && (r_idx == C_LAST)) w_state_nxt = S_FULL;
            S_FULL:  if (w_commit) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        w_ready     = (r_state == S_LOAD);
        w_full      = (r_state == S_FULL);
        w_load_beat = (r_state == S_LOAD) && w_valid;
        w_commit_ok = (r_state == S_FULL) && w_commit;
    end

    // Weight banks are independent of stall so loading overlaps compute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            for (int k = 0; k < COLS; k++) begin
                r_ws[k] <= '0;
                r_wa[k] <= '0;
            end
        end else begin
            if (w_load_beat) begin
                r_ws[r_idx] <= w_data;
                r_idx       <= (r_idx == C_LAST) ? '0 : r_idx + IW'(1);
            end
            if (w_commit_ok) begin
                for (int k = 0; k < COLS; k++) begin
                    r_wa[k] <= r_ws[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Activation skew chain: column 0 taps the inputs directly.
    // ------------------------------------------------------------------
    logic [DW-1:0]    r_xs [1:COLS-1];
    logic [COLS-1:1]  r_vs;
    logic [DW-1:0]    w_xk [COLS];
    logic [COLS-1:0]  w_vk;

    always_comb begin
        w_xk[0] = xi;
        w_vk[0] = x_valid;
        for (int k = 1; k < COLS; k++) begin
            w_xk[k] = r_xs[k];
            w_vk[k] = r_vs[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs <= '0;
            for (int k = 1; k < COLS; k++) begin
                r_xs[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 1; k < COLS; k++) begin
                r_xs[k] <= w_xk[k-1];
                r_vs[k] <= w_vk[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-column multiply-accumulate and result fitting
    // ------------------------------------------------------------------
    logic [COLS-1:0][OW-1:0] w_fit;

    generate
        for (genvar k = 0; k < COLS; k++) begin : g_col
            logic [FW-1:0] w_xe;
            logic [FW-1:0] w_we;
            logic [FW-1:0] w_ce;
            logic [FW-1:0] w_sum;
            logic [OW-1:0] w_res;

            // Extending both operands to FW makes the low FW bits of the
            // product correct in either signedness mode.
            assign w_xe  = {{(FW-DW){sgn & w_xk[k][DW-1]}}, w_xk[k]};
            assign w_we  = {{(FW-WW){sgn & r_wa[k][WW-1]}}, r_wa[k]};
            assign w_ce  = {{(FW-CW){sgn & ci[k*CW+CW-1]}}, ci[k*CW +: CW]};
            assign w_sum = (w_xe * w_we) + w_ce;

            if (FW == OW) begin : g_eq
                assign w_res = w_sum;
            end else if (FW < OW) begin : g_ext
                assign w_res = {{(OW-FW){sgn & w_sum[FW-1]}}, w_sum};
            end else if (SAT != 0) begin : g_sat
                logic w_ovf_s;
                logic w_ovf_u;
                // Signed overflow: the bits above the OW-1 sign are not all copies of it.
                assign w_ovf_s = ~((&w_sum[FW-1:OW-1]) | ~(|w_sum[FW-1:OW-1]));
                assign w_ovf_u = |w_sum[FW-1:OW];
                always_comb begin
                    w_res = w_sum[OW-1:0];
                    if (sgn) begin
                        if (w_ovf_s) begin
                            w_res = w_sum[FW-1] ? {1'b1, {(OW-1){1'b0}}}
                                                : {1'b0, {(OW-1){1'b1}}};
                        end
                    end else if (w_ovf_u) begin
                        w_res = '1;
                    end
                end
            end else begin : g_wrap
                assign w_res = w_sum[OW-1:0];
            end

            assign w_fit[k] = w_res;
        end
    endgenerate

    logic [OW-1:0]   r_co [COLS];
    logic [COLS-1:0] r_cv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cv <= '0;
            for (int k = 0; k < COLS; k++) begin
                r_co[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < COLS; k++) begin
                // A bubble keeps the previous result visible.
                if (w_vk[k]) begin
                    r_co[k] <= w_fit[k];
                end
                r_cv[k] <= w_vk[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < COLS; k++) begin : g_out
            assign co[k*OW +: OW] = r_co[k];
        end
    endgenerate

    assign co_valid = r_cv;

endmodule
`default_nettype wire

// File: tb/tb_mac_row_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_row_pipe
// Purpose  : Self-checking bench for mac_row_pipe. Expected column results
//            are queued per column when a beat is driven and compared when
//            the column raises co_valid; two extra OW=12 instances cover the
//            saturating and wrapping result paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_row_pipe;

    localparam int COLS = 6;
    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int CW   = 16;
    localparam int OW   = 17;
    localparam int OWS  = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stall;
    logic                 sgn;
    logic                 x_valid;
    logic [DW-1:0]        xi;
    logic [COLS*CW-1:0]   ci;
    logic                 w_valid;
    logic [WW-1:0]        w_data;
    logic                 w_commit;

    wire                  w_ready;
    wire                  w_full;
    wire [COLS*OW-1:0]    co;
    wire [COLS-1:0]       co_valid;

    wire                  s_ready, s_full, r_ready, r_full;
    wire [COLS*OWS-1:0]   co_s, co_w;
    wire [COLS-1:0]       cv_s, cv_w;

    always #5 clk = ~clk;

    mac_row_pipe #(.DW(DW), .WW(WW), .CW(CW), .OW(OW), .COLS(COLS), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .sgn(sgn), .x_valid(x_valid), .xi(xi),
        .ci(ci), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_commit(w_commit), .w_full(w_full), .co(co), .co_valid(co_valid)
    );

    mac_row_pipe #(.DW(DW), .WW(WW), .CW(CW), .OW(OWS), .COLS(COLS), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .sgn(sgn), .x_valid(x_valid), .xi(xi),
        .ci(ci), .w_valid(w_valid), .w_ready(s_ready), .w_data(w_data),
        .w_commit(w_commit), .w_full(s_full), .co(co_s), .co_valid(cv_s)
    );

    mac_row_pipe #(.DW(DW), .WW(WW), .CW(CW), .OW(OWS), .COLS(COLS), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .sgn(sgn), .x_valid(x_valid), .xi(xi),
        .ci(ci), .w_valid(w_valid), .w_ready(r_ready), .w_data(w_data),
        .w_commit(w_commit), .w_full(r_full), .co(co_w), .co_valid(cv_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state
    logic [WW-1:0] m_wa [COLS];
    logic [WW-1:0] m_ws [COLS];
    logic [WW-1:0] tw   [COLS];
    bit            m_full;

    logic [OW-1:0] q_val [COLS][$];
    int            q_due [COLS][$];
    int            adv_cnt  = 0;
    bit            adv_last = 1'b0;

    function automatic logic [OW-1:0] fit17(input longint v, input bit s);
        longint hi, lo;
        if (s) begin hi = 65535;  lo = -65536; end
        else   begin hi = 131071; lo = 0;      end
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return OW'(v);
    endfunction

    function automatic logic [OW-1:0] f_exp(input int k, input logic [DW-1:0] x);
        longint xv, wv, cv;
        logic [CW-1:0] c;
        logic [WW-1:0] w;
        c  = ci[k*CW +: CW];
        w  = m_wa[k];
        xv = sgn ? longint'($signed(x)) : longint'(x);
        wv = sgn ? longint'($signed(w)) : longint'(w);
        cv = sgn ? longint'($signed(c)) : longint'(c);
        return fit17(cv + xv * wv, sgn);
    endfunction

    // Count datapath-advancing edges; every expected pulse is due at a fixed count.
    always @(posedge clk) begin
        if (rst) begin
            adv_last = 1'b0;
        end else begin
            adv_last = !stall;
            if (!stall) adv_cnt++;
        end
    end

    logic [OW-1:0] prev_co [COLS];
    logic [COLS-1:0] prev_v;
    logic [OW-1:0] mon_c;
    bit            mon_p;

    always @(negedge clk) begin
        for (int k = 0; k < COLS; k++) begin
            mon_c = co[k*OW +: OW];
            if (!rst) begin
                if (adv_last) begin
                    mon_p = (q_due[k].size() > 0) && (q_due[k][0] == adv_cnt);
                    check($sformatf("co_valid[%0d]", k), 32'(co_valid[k]), 32'(mon_p));
                    if (co_valid[k] && mon_p) begin
                        check($sformatf("co[%0d]", k), 32'(mon_c), 32'(q_val[k][0]));
                        void'(q_val[k].pop_front());
                        void'(q_due[k].pop_front());
                    end else if (!co_valid[k]) begin
                        check($sformatf("bubble_hold[%0d]", k), 32'(mon_c), 32'(prev_co[k]));
                    end
                end else begin
                    check($sformatf("stall_hold_co[%0d]", k), 32'(mon_c), 32'(prev_co[k]));
                    check($sformatf("stall_hold_v[%0d]", k), 32'(co_valid[k]), 32'(prev_v[k]));
                end
            end
            prev_co[k] = mon_c;
            prev_v[k]  = co_valid[k];
        end
    end

    task automatic drive(input bit xv, input logic [DW-1:0] x, input bit st, input bit cm);
        x_valid  = xv;
        xi       = x;
        stall    = st;
        w_commit = cm;
        if (xv && !st) begin
            for (int k = 0; k < COLS; k++) begin
                q_val[k].push_back(f_exp(k, x));
                q_due[k].push_back(adv_cnt + k + 1);
            end
        end
        // Commit lands at this edge: the beat above still used the old weights.
        if (cm && m_full) begin
            for (int k = 0; k < COLS; k++) m_wa[k] = m_ws[k];
            m_full = 1'b0;
        end
        @(posedge clk); #1;
        x_valid  = 1'b0;
        stall    = 1'b0;
        w_commit = 1'b0;
    endtask

    task automatic drain();
        repeat (COLS + 2) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load_w();
        for (int i = 0; i < COLS; i++) begin
            check("w_ready_load", 32'(w_ready), 32'd1);
            w_valid = 1'b1;
            w_data  = tw[i];
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        for (int k = 0; k < COLS; k++) m_ws[k] = tw[k];
        m_full = 1'b1;
        check("w_full_after_load", 32'(w_full), 32'd1);
        check("w_ready_when_full", 32'(w_ready), 32'd0);
    endtask

    task automatic load_commit();
        load_w();
        drive(1'b0, '0, 1'b0, 1'b1);
        check("w_full_after_commit", 32'(w_full), 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; sgn = 1'b0; x_valid = 1'b0; xi = '0; ci = '0;
        w_valid = 1'b0; w_data = '0; w_commit = 1'b0; m_full = 1'b0;
        for (int k = 0; k < COLS; k++) begin m_wa[k] = '0; m_ws[k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_co", 32'(|co), 32'd0);
        check("rst_co_valid", 32'(co_valid), 32'd0);
        check("rst_w_ready", 32'(w_ready), 32'd1);
        check("rst_w_full", 32'(w_full), 32'd0);
        rst = 1'b0;

        // Skew/latency: w=1..6, single beat xi=3
        for (int k = 0; k < COLS; k++) tw[k] = 8'(k + 1);
        load_commit();
        drive(1'b1, 8'd3, 1'b0, 1'b0);
        drain();
        for (int k = 0; k < COLS; k++)
            check($sformatf("skew_co[%0d]", k), 32'(co[k*OW +: OW]), 32'(3 * (k + 1)));

        // Reset in the middle of a weight load (idx=3)
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1; w_data = 8'(11 + i);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_co", 32'(|co), 32'd0);
        check("midrst_co_valid", 32'(co_valid), 32'd0);
        check("midrst_w_ready", 32'(w_ready), 32'd1);
        check("midrst_w_full", 32'(w_full), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_full = 1'b0;
        for (int k = 0; k < COLS; k++) begin m_wa[k] = '0; m_ws[k] = '0; end
        for (int k = 0; k < COLS; k++) tw[k] = 8'(7 + k);
        load_commit();
        drive(1'b1, 8'd5, 1'b0, 1'b0);
        drain();
        check("postrst_col0", 32'(co[0 +: OW]), 32'd35);
        check("postrst_col5", 32'(co[5*OW +: OW]), 32'd60);

        // Signed / unsigned extremes on column 0
        tw[0] = 8'h80;
        for (int k = 1; k < COLS; k++) tw[k] = 8'd1;
        load_commit();
        sgn = 1'b1; ci = '0; ci[CW-1:0] = 16'h8000;
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        drain();
        check("signed_co0", 32'(co[0 +: OW]), 32'h1C000);
        sgn = 1'b0;
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        drain();
        check("unsigned_co0", 32'(co[0 +: OW]), 32'd49152);

        // Saturation and wrap at OW=12
        for (int k = 0; k < COLS; k++) tw[k] = 8'd127;
        load_commit();
        sgn = 1'b1; ci = '0;
        drive(1'b1, 8'd127, 1'b0, 1'b0);
        check("sat_pos", 32'(co_s[OWS-1:0]), 32'd2047);
        check("wrap_pos", 32'(co_w[OWS-1:0]), 32'hF01);
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        check("sat_neg", 32'(co_s[OWS-1:0]), 32'h800);
        check("wrap_neg", 32'(co_w[OWS-1:0]), 32'h080);
        drain();
        for (int k = 0; k < COLS; k++) tw[k] = 8'd255;
        load_commit();
        sgn = 1'b0;
        drive(1'b1, 8'd255, 1'b0, 1'b0);
        check("sat_uns", 32'(co_s[OWS-1:0]), 32'd4095);
        check("wrap_uns", 32'(co_w[OWS-1:0]), 32'hE01);
        drain();

        // Stall and bubble
        for (int k = 0; k < COLS; k++) tw[k] = 8'(k + 1);
        load_commit();
        for (int k = 0; k < COLS; k++) ci[k*CW +: CW] = 16'(1000 * k);
        drive(1'b1, 8'd10, 1'b0, 1'b0);
        drive(1'b1, 8'd20, 1'b0, 1'b0);
        drive(1'b0, 8'd99, 1'b0, 1'b0);
        drive(1'b1, 8'd30, 1'b0, 1'b0);
        drive(1'b1, 8'd77, 1'b1, 1'b0);
        drive(1'b0, 8'd0,  1'b1, 1'b0);
        drive(1'b1, 8'd40, 1'b0, 1'b0);
        drain();

        // Loader: extra beats dropped, commit straddling a compute
        tw[0] = 8'd2;
        for (int k = 1; k < COLS; k++) tw[k] = 8'(k + 1);
        load_w();
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1; w_data = 8'hAA;
            @(posedge clk); #1;
            check("extra_w_ready", 32'(w_ready), 32'd0);
            check("extra_w_full", 32'(w_full), 32'd1);
        end
        w_valid = 1'b0;
        ci = '0;
        drive(1'b1, 8'd10, 1'b0, 1'b1);
        drive(1'b1, 8'd10, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("commit_in_load_full", 32'(w_full), 32'd0);
        check("commit_in_load_ready", 32'(w_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            w_valid = 1'b1; w_data = 8'd9;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        drive(1'b1, 8'd10, 1'b0, 1'b1);
        drain();

        // Random stream with stalls and bubbles
        sgn = 1'b1;
        ci  = {COLS{16'($urandom)}};
        for (int k = 0; k < COLS; k++) ci[k*CW +: CW] = 16'($urandom);
        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0, 1'b0);
        drain();

        for (int k = 0; k < COLS; k++)
            check($sformatf("queue_empty[%0d]", k), 32'(q_val[k].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
